dac_mode_sequencer: RTL and testbench
=====================================

Name: dac_mode_sequencer

Overview:
- Sequences every DAC mode change commanded by the MCU: sample-rate family, rate, DSD/PCM and reset requests.
- Each change runs as a glitch-free mute, stop, reset, reconfigure, settle, unmute sequence.
- Sits between the MCU control pins and the DAC control pins.
- Gates the NOS DAC transceiver through a stream-enable output, so the transceiver never drives the DAC while its configuration changes.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for all MCU inputs (min 2).
- STABLE_CYC, 1024, cycles a new MCU config must hold unchanged before it is accepted.
- MUTE_CYC, 4096, cycles mute is held before the stream is stopped.
- RST_CYC, 256, cycles dac_reset is held active.
- SETTLE_CYC, 8192, cycles after reset release before unmute.
- CNT_W, 16, phase counter width; must satisfy 2**CNT_W > max of all *_CYC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mcu_44_48  in  1  async; 0=44.1k family, 1=48k family
- mcu_f  in  2  async; rate multiplier select
- mcu_dsd_on  in  1  async; 1 = DSD requested
- mcu_mute  in  1  async; user mute request
- mcu_dac_reset  in  1  async; active-low forced DAC reset request
- dac_44_48  out  1  applied rate family
- dac_f  out  2  applied rate select
- dac_dsd  out  1  applied mode; 0=DSD, 1=PCM (inverted from mcu_dsd_on)
- dac_mute  out  1  1 = DAC muted
- dac_reset  out  1  active-low DAC reset
- stream_en  out  1  1 = transceiver may run; drives its resetn via top-level sync
- busy  out  1  1 while a sequence is in progress

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: dac_mute=1, dac_reset=0, stream_en=0, busy=1, dac_44_48=0, dac_f=0, dac_dsd=1, state=BOOT.
- Synchronization: all mcu_* inputs pass SYNC_STAGES FFs. The config vector cfg = {44_48, f, dsd_on} is 4 bits, compared against the applied register cfg_q.
- Stability filter:
  - Counter stab_cnt clears whenever synced cfg changes from the previous cycle.
  - pending=1 when synced cfg != cfg_q and stab_cnt reaches STABLE_CYC-1.
  - The filter runs only in RUN.
- States:
  - BOOT: dac_reset=0, mute=1. Wait RST_CYC, latch cfg_q <= synced cfg, go SETTLE.
  - RUN: mute = synced mcu_mute, stream_en=1, busy=0, dac_reset=1.
    - pending -> MUTE.
    - synced mcu_dac_reset==0 -> MUTE.
    - pending has priority in labelling only; both follow the same path.
  - MUTE: dac_mute=1, stream_en=1. After MUTE_CYC go STOP.
  - STOP: stream_en=0 for exactly 1 cycle, then RESET.
  - RESET: dac_reset=0. On entry cycle, cfg_q <= synced cfg and dac_* outputs update. Hold RST_CYC cycles; also hold while synced mcu_dac_reset==0. Then go SETTLE.
  - SETTLE: dac_reset=1, mute=1, stream_en=0. After SETTLE_CYC go RUN; stream_en and mute release on the same cycle RUN is entered.
- Counter: one phase counter cnt, cleared on every state transition. A phase of N cycles exits when cnt==N-1, so the state is held exactly N cycles.
- Config outputs: dac_44_48/dac_f/dac_dsd are registered from cfg_q and change only on the RESET entry cycle (or BOOT exit). They never change while dac_reset=1.
- Config change mid-sequence: ignored until RUN. Because cfg_q holds the value latched at RESET entry, a later difference re-triggers a full sequence after STABLE_CYC in RUN.
- mcu_dac_reset asserted mid-sequence: no abort; its effect is only extending RESET.
- mcu_mute in a non-RUN state: no effect; dac_mute stays 1.
- Async reset mid-sequence: immediate return to reset values, then the BOOT sequence.
- Latency after a stable config change: STABLE_CYC + MUTE_CYC + 1 + RST_CYC + SETTLE_CYC cycles from cfg stable at the sync output to unmute, plus SYNC_STAGES.
- Assertions:
  - stream_en=1 never while dac_reset=0.
  - dac_mute=1 whenever state != RUN.

Decomposition:
- Package snos_pkg holds:
  - typedef enum logic [2:0] seq_state_t {BOOT, RUN, MUTE, STOP, RESET, SETTLE}.
  - typedef struct packed dac_cfg_t {logic fam48; logic [1:0] f; logic dsd_on;}.
  - Default cycle constants.
- One sub-module: snos_sync (SYNC_STAGES-deep, WIDTH-parameterized bit synchronizer), instantiated once over all MCU inputs.

Test Plan:
Bench uses STABLE_CYC=4, MUTE_CYC=8, RST_CYC=3, SETTLE_CYC=5.
- Boot: release reset with cfg=4'b0100.
  - dac_reset low exactly 3 cycles, then 5 mute cycles.
  - At RUN: dac_f=2'b10, dac_dsd=1, stream_en=1, busy=0.
- Stable change: in RUN, set mcu_f 2'b10->2'b01 and hold.
  - After sync+4 cycles, dac_mute=1 for 8 cycles, then stream_en=0.
  - dac_reset=0 for 3 cycles; dac_f=01 changes on the cycle dac_reset falls.
  - Unmute 5 cycles after reset release.
- Glitch rejection: toggle mcu_dsd_on for 3 cycles, then restore. No state change; dac_mute stays at mcu_mute value.
- Forced reset: pulse mcu_dac_reset low for 20 cycles in RUN.
  - Full sequence runs; dac_reset stays low until the input goes high, then SETTLE of 5.
- Change during SETTLE: modify mcu_44_48 in SETTLE.
  - Outputs unchanged until RUN, then a second full sequence.
  - dac_44_48 updates only at its RESET entry.
- Async reset in MUTE: assert reset mid-MUTE. All outputs return to reset values in the same cycle, then BOOT replays.

Source files
------------

// File: rtl/snos_pkg.sv
// ---------------------------------------------------------------------------
// snos_pkg
// Shared types and default timing constants for the DAC mode sequencer.
//   seq_state_t : sequencer phases
//   dac_cfg_t   : MCU-requested DAC configuration {fam48, f, dsd_on}
// ---------------------------------------------------------------------------
package snos_pkg;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        MUTE,
        STOP,
        RESET,
        SETTLE
    } seq_state_t;

    typedef struct packed {
        logic       fam48;
        logic [1:0] f;
        logic       dsd_on;
    } dac_cfg_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_STABLE_CYC  = 1024;
    localparam int unsigned DEF_MUTE_CYC    = 4096;
    localparam int unsigned DEF_RST_CYC     = 256;
    localparam int unsigned DEF_SETTLE_CYC  = 8192;
    localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/snos_sync.sv
// ---------------------------------------------------------------------------
// snos_sync
// Multi-stage flop synchronizer for a bundle of asynchronous single-bit inputs.
// Each bit is synchronized independently; no coherency across bits is implied.
//   clk     : destination clock
//   reset   : asynchronous active-high reset, clears all stages
//   data_i  : asynchronous inputs
//   data_o  : synchronized outputs (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module snos_sync #(
    parameter int unsigned WIDTH       = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], data_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/dac_mode_sequencer.sv
// ---------------------------------------------------------------------------
// dac_mode_sequencer
// Applies MCU-requested DAC mode changes through a glitch-free
// mute -> stop -> reset -> reconfigure -> settle -> unmute sequence, and gates
// the NOS transceiver (stream_en) so it never drives the DAC mid-reconfig.
//   clk, reset          : system clock, asynchronous active-high reset
//   mcu_*               : asynchronous MCU requests (synchronized internally)
//   dac_44_48/f/dsd     : applied configuration (dac_dsd: 0=DSD, 1=PCM)
//   dac_mute            : 1 = DAC muted
//   dac_reset           : active-low DAC reset
//   stream_en           : 1 = transceiver may run
//   busy                : 1 while a sequence is in progress
// ---------------------------------------------------------------------------
module dac_mode_sequencer
    import snos_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYC  = DEF_STABLE_CYC,
    parameter int unsigned MUTE_CYC    = DEF_MUTE_CYC,
    parameter int unsigned RST_CYC     = DEF_RST_CYC,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mcu_44_48,
    input  logic [1:0] mcu_f,
    input  logic       mcu_dsd_on,
    input  logic       mcu_mute,
    input  logic       mcu_dac_reset,
    output logic       dac_44_48,
    output logic [1:0] dac_f,
    output logic       dac_dsd,
    output logic       dac_mute,
    output logic       dac_reset,
    output logic       stream_en,
    output logic       busy
);

    // Terminal counts: a phase of N cycles exits when the counter reads N-1.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] MUTE_LAST   = CNT_W'(MUTE_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    // ---- Input synchronization -------------------------------------------
    logic [5:0] mcu_raw;
    logic [5:0] mcu_s;
    dac_cfg_t   cfg_s;
    logic       mute_req_s;
    logic       rst_req_n_s;

    assign mcu_raw = {mcu_44_48, mcu_f, mcu_dsd_on, mcu_mute, mcu_dac_reset};

    snos_sync #(
        .WIDTH       (6),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .data_i (mcu_raw),
        .data_o (mcu_s)
    );

    assign cfg_s       = dac_cfg_t'(mcu_s[5:2]);
    assign mute_req_s  = mcu_s[1];
    assign rst_req_n_s = mcu_s[0];

    // ---- State -------------------------------------------------------------
    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    dac_cfg_t         cfg_q, cfg_d;
    dac_cfg_t         cfg_prev_q;
    logic             dac_mute_q, dac_mute_d;
    logic             dac_reset_q, dac_reset_d;
    logic             stream_en_q, stream_en_d;
    logic             busy_q, busy_d;
    logic             pending;

    // ---- Stability filter ------------------------------------------------
    // The comparison against cfg_prev_q keeps a one-cycle glitch from firing
    // off a counter that is still saturated from an earlier stable value.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (state_q != RUN || cfg_s != cfg_prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STABLE_LAST) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    assign pending = (state_q == RUN) && (cfg_s == cfg_prev_q) && (cfg_s != cfg_q)
                   && (stab_cnt_q == STABLE_LAST);

    // ---- Sequencer next state ----------------------------------------------
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        unique case (state_q)
            BOOT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = SETTLE;
                    cfg_d   = cfg_s;
                end
            end
            RUN: begin
                // Config change and forced reset share the same path.
                if (pending || !rst_req_n_s) begin
                    state_d = MUTE;
                end
            end
            MUTE: begin
                if (cnt_q == MUTE_LAST) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Latch on RESET entry so dac_* change together with dac_reset falling.
                state_d = RESET;
                cfg_d   = cfg_s;
            end
            RESET: begin
                if (cnt_q >= RST_LAST && rst_req_n_s) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Phase counter: cleared on any transition, saturates so an extended
    // RESET cannot wrap back below the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || state_q == RUN) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        dac_mute_d  = (state_d == RUN) ? mute_req_s : 1'b1;
        stream_en_d = (state_d == RUN) || (state_d == MUTE);
        dac_reset_d = !((state_d == BOOT) || (state_d == RESET));
        busy_d      = (state_d != RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BOOT;
            cnt_q       <= '0;
            stab_cnt_q  <= '0;
            cfg_q       <= '0;
            cfg_prev_q  <= '0;
            dac_mute_q  <= 1'b1;
            dac_reset_q <= 1'b0;
            stream_en_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            cfg_q       <= cfg_d;
            cfg_prev_q  <= cfg_s;
            dac_mute_q  <= dac_mute_d;
            dac_reset_q <= dac_reset_d;
            stream_en_q <= stream_en_d;
            busy_q      <= busy_d;
        end
    end

    assign dac_44_48 = cfg_q.fam48;
    assign dac_f     = cfg_q.f;
    assign dac_dsd   = ~cfg_q.dsd_on;
    assign dac_mute  = dac_mute_q;
    assign dac_reset = dac_reset_q;
    assign stream_en = stream_en_q;
    assign busy      = busy_q;

    // ---- Safety properties -------------------------------------------------
    a_stream_off_in_reset : assert property (
        @(posedge clk) disable iff (reset) !(stream_en_q && !dac_reset_q));

    a_muted_outside_run : assert property (
        @(posedge clk) disable iff (reset) (state_q != RUN) |-> dac_mute_q);

endmodule

// File: tb/tb_dac_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_mode_sequencer
// Directed bench for dac_mode_sequencer with short phase lengths
// (STABLE=4, MUTE=8, RST=3, SETTLE=5, SYNC=2). Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dac_mode_sequencer;

    localparam int unsigned SYNC_N   = 2;
    localparam int unsigned STABLE_N = 4;
    localparam int unsigned MUTE_N   = 8;
    localparam int unsigned RST_N    = 3;
    localparam int unsigned SETTLE_N = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mcu_44_48;
    logic [1:0] mcu_f;
    logic       mcu_dsd_on;
    logic       mcu_mute;
    logic       mcu_dac_reset;
    logic       dac_44_48;
    logic [1:0] dac_f;
    logic       dac_dsd;
    logic       dac_mute;
    logic       dac_reset;
    logic       stream_en;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dac_mode_sequencer #(
        .SYNC_STAGES (SYNC_N),
        .STABLE_CYC  (STABLE_N),
        .MUTE_CYC    (MUTE_N),
        .RST_CYC     (RST_N),
        .SETTLE_CYC  (SETTLE_N),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mcu_44_48     (mcu_44_48),
        .mcu_f         (mcu_f),
        .mcu_dsd_on    (mcu_dsd_on),
        .mcu_mute      (mcu_mute),
        .mcu_dac_reset (mcu_dac_reset),
        .dac_44_48     (dac_44_48),
        .dac_f         (dac_f),
        .dac_dsd       (dac_dsd),
        .dac_mute      (dac_mute),
        .dac_reset     (dac_reset),
        .stream_en     (stream_en),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // {dac_44_48, dac_f, dac_dsd, dac_mute, dac_reset, stream_en, busy}
    function automatic int out_vec();
        return int'({dac_44_48, dac_f, dac_dsd, dac_mute, dac_reset, stream_en, busy});
    endfunction

    function automatic int vec(input logic fam, input logic [1:0] f, input logic dsd,
                               input logic mute, input logic rstn, input logic se,
                               input logic bsy);
        return int'({fam, f, dsd, mute, rstn, se, bsy});
    endfunction

    function automatic int cfg_out();
        return int'({dac_44_48, dac_f, dac_dsd});
    endfunction

    // 0: reset low, 1: MUTE phase, 2: STOP/SETTLE phase, 3: unmuted
    function automatic logic sel_val(input int sel);
        case (sel)
            0:       return !dac_reset;
            1:       return dac_mute && stream_en && dac_reset;
            2:       return !stream_en && dac_reset && dac_mute;
            3:       return !dac_mute;
            default: return 1'b0;
        endcase
    endfunction

    // Count consecutive falling-edge samples where the selected condition holds.
    task automatic count_run(input int sel, output int n);
        n = 0;
        while (sel_val(sel) && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Walks one full sequence; optionally changes mcu_44_48 at first SETTLE sample.
    task automatic check_sequence(input string tag, input int unmuted, input int rst_low,
                                  input int cfg_old, input int cfg_new,
                                  input bit change_in_settle);
        int n;
        count_run(3, n);
        check_eq({tag, "_unmuted"}, n, unmuted);
        check_eq({tag, "_cfg_before"}, cfg_out(), cfg_old);
        count_run(1, n);
        check_eq({tag, "_mute"}, n, MUTE_N);
        count_run(2, n);
        check_eq({tag, "_stop"}, n, 1);
        check_eq({tag, "_cfg_at_reset"}, cfg_out(), cfg_new);
        count_run(0, n);
        check_eq({tag, "_reset_low"}, n, rst_low);
        if (change_in_settle) begin
            mcu_44_48 = 1'b1;
        end
        count_run(2, n);
        check_eq({tag, "_settle"}, n, SETTLE_N);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  busy_seen;
        bit  mute_dropped;

        mcu_44_48     = 1'b0;
        mcu_f         = 2'b10;
        mcu_dsd_on    = 1'b0;
        mcu_mute      = 1'b0;
        mcu_dac_reset = 1'b1;

        // Boot
        repeat (3) @(negedge clk);
        check_eq("reset_vals", out_vec(), vec(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        reset = 1'b0;
        count_run(0, n);
        check_eq("boot_reset_low", n, RST_N);
        count_run(2, n);
        check_eq("boot_settle", n, SETTLE_N);
        check_eq("boot_run", out_vec(), vec(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));

        // Stable rate change 10 -> 01
        @(negedge clk);
        mcu_f = 2'b01;
        @(negedge clk);
        check_sequence("chg", SYNC_N + STABLE_N, RST_N, 4'b0101, 4'b0011, 1'b0);
        check_eq("chg_run", out_vec(), vec(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));

        // User mute follows in RUN; a 3-cycle DSD glitch is rejected
        mcu_mute = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("user_mute", out_vec(), vec(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        mcu_dsd_on = 1'b1;
        repeat (3) @(negedge clk);
        mcu_dsd_on   = 1'b0;
        busy_seen    = 1'b0;
        mute_dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (!dac_mute) mute_dropped = 1'b1;
        end
        check_eq("glitch_busy", int'(busy_seen), 0);
        check_eq("glitch_mute_held", int'(mute_dropped), 0);
        mcu_mute = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("unmute_run", out_vec(), vec(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));

        // Forced DAC reset held low for 20 cycles
        mcu_dac_reset = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                mcu_dac_reset = 1'b1;
            end
            begin
                @(negedge clk);
                check_sequence("frc", SYNC_N, 11, 4'b0011, 4'b0011, 1'b0);
            end
        join
        check_eq("frc_run", out_vec(), vec(1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));

        // Change during SETTLE: first sequence applies f=10, second applies fam48
        mcu_f = 2'b10;
        @(negedge clk);
        check_sequence("stl", SYNC_N + STABLE_N, RST_N, 4'b0011, 4'b0101, 1'b1);
        check_eq("stl_run", out_vec(), vec(1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        check_sequence("stl2", STABLE_N, RST_N, 4'b0101, 4'b1101, 1'b0);
        check_eq("stl2_run", out_vec(), vec(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));

        // Async reset in MUTE, then BOOT replay applies DSD
        mcu_dsd_on = 1'b1;
        @(negedge clk);
        count_run(3, n);
        check_eq("ar_unmuted", n, SYNC_N + STABLE_N);
        repeat (3) @(negedge clk);
        check_eq("ar_in_mute", out_vec(), vec(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
        #1 reset = 1'b1;
        #1 check_eq("ar_reset_vals", out_vec(),
                    vec(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        reset = 1'b0;
        count_run(0, n);
        check_eq("ar_boot_reset_low", n, RST_N);
        count_run(2, n);
        check_eq("ar_boot_settle", n, SETTLE_N);
        check_eq("ar_run", out_vec(), vec(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
